// File: rtl/uart_cfg_arbiter_pkg.sv
// Shared constants, FSM encoding and frame helpers for the multi-requester
// UART config arbiter.
package uart_cfg_arbiter_pkg;

    localparam int         UART_FRAME_LEN = 6;
    localparam logic [2:0] LAST_BYTE_IDX  = 3'(UART_FRAME_LEN - 1);
    localparam logic [7:0] DEF_HEAD0      = 8'hFF;
    localparam logic [7:0] DEF_HEAD1      = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic [7:0] frame_csum(input logic [7:0]  addr,
                                              input logic [15:0] value);
        return addr + value[15:8] + value[7:0];
    endfunction

    // Byte order on the wire: HEAD0, HEAD1, ADDR, VAL_H, VAL_L, CSUM.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [7:0]  head0,
                                              input logic [7:0]  head1,
                                              input logic [7:0]  addr,
                                              input logic [15:0] value,
                                              input logic [7:0]  csum);
        logic [7:0] b;
        case (idx)
            3'd0:    b = head0;
            3'd1:    b = head1;
            3'd2:    b = addr;
            3'd3:    b = value[15:8];
            3'd4:    b = value[7:0];
            3'd5:    b = csum;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cfg_arbiter_rr.sv
// Round-robin arbiter: the search begins one past the last granted index and the
// pointer moves to the winner whenever a grant is taken.
module uart_cfg_arbiter_rr
    import uart_cfg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] pending,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [2:0]         gnt_idx,
    output logic               gnt_vld
);

    logic [2:0] ptr_q, ptr_d;
    int         cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = 3'd0;
        gnt_vld    = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_vld && (|(pending & (NUM_REQ'(1) << cand)))) begin
                gnt_vld = 1'b1;
                gnt_idx = 3'(cand);
            end
        end
        if (gnt_vld) begin
            gnt_onehot = NUM_REQ'(1) << gnt_idx;
        end

        ptr_d = ptr_q;
        if (en && gnt_vld) begin
            ptr_d = gnt_idx;
        end
    end

    // Reset value makes requester 0 the first candidate after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 3'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_cfg_arbiter.sv
// Shares one UART TX byte channel among NUM_REQ config requesters, sending each
// request as a 6-byte frame with header and checksum.
module uart_cfg_arbiter
    import uart_cfg_arbiter_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter logic [7:0] UART_HEAD0 = DEF_HEAD0,
    parameter logic [7:0] UART_HEAD1 = DEF_HEAD1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*8-1:0]  req_addr,
    input  logic [NUM_REQ*16-1:0] req_value,
    output logic [NUM_REQ-1:0]    done,
    output logic [7:0]            tx_data,
    output logic                  tx_vld,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic [2:0]            state_dbg
);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   req_q, req_d;
    logic [NUM_REQ-1:0]   req_edge;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [2:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           addr_q, addr_d;
    logic [15:0]          value_q, value_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_vld_q, tx_vld_d;

    logic [NUM_REQ-1:0]   arb_onehot;
    logic [2:0]           arb_idx;
    logic                 arb_vld;
    logic [7:0]           win_addr;
    logic [15:0]          win_value;

    uart_cfg_arbiter_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .pending    (pending_q),
        .en         (state_q == ST_IDLE),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_vld    (arb_vld)
    );

    always_comb begin
        win_addr  = 8'(req_addr >> (8 * int'(arb_idx)));
        win_value = 16'(req_value >> (16 * int'(arb_idx)));
    end

    always_comb begin
        req_d      = req;
        req_edge   = req & ~req_q;
        state_d    = state_q;
        // The served requester keeps its pending bit set, so repeat edges merge.
        pending_d  = pending_q | req_edge;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        value_d    = value_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_id_d = arb_idx;
                    grant_oh_d = arb_onehot;
                    byte_idx_d = 3'd0;
                    addr_d     = win_addr;
                    value_d    = win_value;
                    csum_d     = frame_csum(win_addr, win_value);
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = frame_byte(byte_idx_q, UART_HEAD0, UART_HEAD1,
                                           addr_q, value_q, csum_q);
                    state_d   = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_ready) begin
                    if (byte_idx_q == LAST_BYTE_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                pending_d = pending_d & ~grant_oh_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            pending_q  <= '0;
            grant_id_q <= 3'd0;
            grant_oh_q <= '0;
            byte_idx_q <= 3'd0;
            addr_q     <= 8'h00;
            value_q    <= 16'h0000;
            csum_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pending_q  <= pending_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            value_q    <= value_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
        end
    end

    // busy drops in the DONE cycle so it falls together with the done pulse.
    always_comb begin
        busy      = (state_q == ST_SEND) || (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
        done      = (state_q == ST_DONE) ? grant_oh_q : '0;
        tx_data   = tx_data_q;
        tx_vld    = tx_vld_q;
        grant_id  = grant_id_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_uart_cfg_arbiter.sv
// Directed bench for uart_cfg_arbiter with a behavioural uart_tx that goes busy
// one cycle after each strobe and stays busy for 20 cycles.
module tb_uart_cfg_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [31:0]   req_addr = '0;
    logic [63:0]   req_value = '0;
    logic [N-1:0]  done;
    logic [7:0]    tx_data;
    logic          tx_vld;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic [2:0]    grant_id;
    logic [2:0]    state_dbg;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    cap_q[$];
    int            done_log[$];
    int            uart_cnt = 0;
    bit            hold_low = 1'b0;
    bit            done_prev = 1'b0;

    uart_cfg_arbiter #(
        .NUM_REQ    (N),
        .UART_HEAD0 (8'hFF),
        .UART_HEAD1 (8'hAA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_value (req_value),
        .done      (done),
        .tx_data   (tx_data),
        .tx_vld    (tx_vld),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // uart_tx model plus done/strobe monitor, all sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_vld) begin
            checks++;
            if (tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL strobe_while_busy: tx_ready=%0b expected 1", tx_ready);
            end
            cap_q.push_back(tx_data);
            uart_cnt = 20;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
        if (done_prev) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_gap: busy=%0b in cycle after done, expected 0", busy);
            end
        end
        if (done !== '0) begin
            checks++;
            if (busy !== 1'b0 || done !== (4'b1 << grant_id)) begin
                errors++;
                $display("FAIL done_pulse: done=%b busy=%0b grant_id=%0d expected one-hot of grant_id and busy 0",
                         done, busy, grant_id);
            end
            done_log.push_back(int'(grant_id));
        end
        done_prev = (done !== '0);
        tx_ready  = (uart_cnt == 0) && !hold_low;
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [15:0] v);
        req_addr  = (req_addr & ~(32'hFF << (8 * i))) | (32'(a) << (8 * i));
        req_value = (req_value & ~(64'hFFFF << (16 * i))) | (64'(v) << (16 * i));
    endtask

    function automatic void push_frame(input logic [7:0] a, input logic [15:0] v);
        logic [7:0] cs;
        cs = a + v[15:8] + v[7:0];
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hAA);
        exp_q.push_back(a);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(cs);
    endfunction

    task automatic clear_logs();
        exp_q.delete();
        cap_q.delete();
        done_log.delete();
    endtask

    task automatic pulse_req(input logic [N-1:0] mask);
        @(negedge clk);
        req = req | mask;
        repeat (2) @(negedge clk);
        req = req & ~mask;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld: got %0b expected 0", tx_vld); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %0h expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        clear_logs();
        set_req(0, 8'h1B, 16'h0102);
        exp_q = '{8'hFF, 8'hAA, 8'h1B, 8'h01, 8'h02, 8'h1E};
        @(negedge clk);
        req[0] = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_pending_cycle_busy: got %0b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_grant_busy: got %0b expected 1", busy); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL single_grant_id: got %0d expected 0", grant_id); end
        @(negedge clk);
        checks++; if (tx_vld !== 1'b1 || tx_data !== 8'hFF) begin
            errors++; $display("FAIL single_first_strobe: tx_vld=%0b tx_data=%0h expected 1/FF", tx_vld, tx_data);
        end
        req[0] = 1'b0;
        for (int c = 0; c < 1000 && done_log.size() < 1; c++) @(negedge clk);
        checks++; if (done_log.size() < 1) begin errors++; $display("FAIL single_timeout: done count %0d expected 1", done_log.size()); end
        repeat (20) @(negedge clk);
        checks++; if (done_log.size() != 1 || done_log[0] != 0) begin
            errors++; $display("FAIL single_done: count %0d first %0d expected 1 pulse on bit 0",
                               done_log.size(), (done_log.size() > 0) ? done_log[0] : -1);
        end
        checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL single_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %0h expected %0h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_simultaneous();
        int exp_order[5] = '{0, 2, 3, 0, 1};
        clear_logs();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk); rst = 1'b1;
        set_req(0, 8'h10, 16'h2030);
        set_req(2, 8'h21, 16'h4151);
        set_req(3, 8'h32, 16'h6272);
        push_frame(8'h10, 16'h2030);
        push_frame(8'h21, 16'h4151);
        push_frame(8'h32, 16'h6272);
        pulse_req(4'b1101);
        for (int c = 0; c < 3000 && done_log.size() < 3; c++) @(negedge clk);
        set_req(0, 8'h43, 16'h8393);
        set_req(1, 8'h54, 16'hA4B4);
        push_frame(8'h43, 16'h8393);
        push_frame(8'h54, 16'hA4B4);
        pulse_req(4'b0011);
        for (int c = 0; c < 2000 && done_log.size() < 5; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++; if (done_log.size() != 5) begin errors++; $display("FAIL rr_done_count: got %0d expected 5", done_log.size()); end
        for (int i = 0; i < 5 && i < done_log.size(); i++) begin
            checks++; if (done_log[i] != exp_order[i]) begin errors++; $display("FAIL rr_order%0d: got %0d expected %0d", i, done_log[i], exp_order[i]); end
        end
        checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_byte%0d: got %0h expected %0h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_csum_wrap();
        clear_logs();
        set_req(1, 8'hFF, 16'hFFFF);
        exp_q = '{8'hFF, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
        pulse_req(4'b0010);
        for (int c = 0; c < 1000 && done_log.size() < 1; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++; if (done_log.size() != 1 || done_log[0] != 1) begin
            errors++; $display("FAIL csum_done: count %0d expected one pulse on bit 1", done_log.size());
        end
        checks++; if (cap_q.size() != 6) begin errors++; $display("FAIL csum_len: got %0d bytes expected 6", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL csum_byte%0d: got %0h expected %0h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_dup_edge();
        int c;
        clear_logs();
        set_req(1, 8'h5A, 16'hA5C3);
        push_frame(8'h5A, 16'hA5C3);
        pulse_req(4'b0010);
        for (c = 0; c < 50 && !(busy === 1'b1 && grant_id === 3'd1); c++) @(negedge clk);
        checks++; if (c >= 50) begin errors++; $display("FAIL dup_grant_timeout: busy=%0b grant_id=%0d expected 1/1", busy, grant_id); end
        repeat (3) @(negedge clk); req[1] = 1'b1;
        repeat (3) @(negedge clk); req[1] = 1'b0;
        repeat (3) @(negedge clk); req[1] = 1'b1;
        repeat (3) @(negedge clk); req[1] = 1'b0;
        for (int k = 0; k < 1000 && done_log.size() < 1; k++) @(negedge clk);
        repeat (300) @(negedge clk);
        checks++; if (done_log.size() != 1 || done_log[0] != 1) begin
            errors++; $display("FAIL dup_done: count %0d expected exactly one pulse on bit 1", done_log.size());
        end
        checks++; if (cap_q.size() != 6) begin errors++; $display("FAIL dup_len: got %0d bytes expected 6", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL dup_byte%0d: got %0h expected %0h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        clear_logs();
        set_req(3, 8'h12, 16'h3456);
        pulse_req(4'b1000);
        for (c = 0; c < 600 && cap_q.size() < 4; c++) @(negedge clk);
        checks++; if (cap_q.size() < 4) begin errors++; $display("FAIL midrst_timeout: got %0d bytes expected 4", cap_q.size()); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL midrst_tx_vld: got %0b expected 0", tx_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0000", done); end
        checks++; if (state_dbg !== 3'd0 || grant_id !== 3'd0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_regs: state=%0d grant_id=%0d tx_data=%0h expected 0/0/00", state_dbg, grant_id, tx_data);
        end
        rst = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (cap_q.size() != 4) begin errors++; $display("FAIL midrst_no_more_bytes: got %0d bytes expected 4", cap_q.size()); end
        checks++; if (done_log.size() != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_log.size()); end
    endtask

    task automatic test_ready_hold();
        int vld_seen = 0;
        clear_logs();
        set_req(0, 8'hC0, 16'hFFEE);
        push_frame(8'hC0, 16'hFFEE);
        hold_low = 1'b1;
        repeat (2) @(negedge clk);
        req[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_vld === 1'b1) vld_seen++;
        end
        req[0] = 1'b0;
        #1;
        checks++; if (vld_seen != 0) begin errors++; $display("FAIL hold_no_strobe: got %0d strobes expected 0", vld_seen); end
        checks++; if (state_dbg !== 3'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL hold_in_send: state=%0d busy=%0b expected 1/1", state_dbg, busy);
        end
        @(posedge clk); #1 hold_low = 1'b0;
        @(negedge clk); #1;
        checks++; if (tx_ready !== 1'b1 || tx_vld !== 1'b0) begin
            errors++; $display("FAIL hold_release: tx_ready=%0b tx_vld=%0b expected 1/0", tx_ready, tx_vld);
        end
        @(posedge clk); #1;
        checks++; if (tx_vld !== 1'b1 || tx_data !== 8'hFF) begin
            errors++; $display("FAIL hold_strobe_after_rise: tx_vld=%0b tx_data=%0h expected 1/FF", tx_vld, tx_data);
        end
        for (int c = 0; c < 1000 && done_log.size() < 1; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++; if (done_log.size() != 1 || done_log[0] != 0) begin
            errors++; $display("FAIL hold_done: count %0d expected one pulse on bit 0", done_log.size());
        end
        checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL hold_byte%0d: got %0h expected %0h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_csum_wrap();
        test_dup_edge();
        test_reset_mid();
        test_ready_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
